// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: turns an EX-stage redirect request into a one-cycle PC load,
// deferring it while instruction memory is busy, and parks the core on HALT.
module pc_redirect_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        PCSrc,
    input  logic [15:0] branch_target,
    input  logic        halt,
    input  logic        imem_busy,
    output logic        redirect,
    output logic [15:0] redirect_pc,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        pc_hold,
    output logic        halted,
    output logic [7:0]  redirect_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] target_q, target_d;
    logic [7:0]  count_q, count_d;

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        pc_hold     = 1'b0;
        halted      = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (ex_valid && halt) begin
                        pc_hold    = 1'b1;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        state_d    = ST_HALT;
                    end else if (ex_valid && PCSrc) begin
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        if (imem_busy) begin
                            // Fetch cannot take the new PC yet; remember it and freeze.
                            target_d = branch_target;
                            pc_hold  = 1'b1;
                            state_d  = ST_PEND;
                        end else begin
                            redirect    = 1'b1;
                            redirect_pc = branch_target;
                        end
                    end
                end
                ST_PEND: begin
                    // EX holds wrong-path work here, so its requests are not looked at.
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    if (imem_busy) begin
                        pc_hold = 1'b1;
                    end else begin
                        redirect    = 1'b1;
                        redirect_pc = target_q;
                        state_d     = ST_RUN;
                    end
                end
                ST_HALT: begin
                    pc_hold = 1'b1;
                    halted  = 1'b1;
                end
                default: state_d = ST_RUN;
            endcase
        end

        count_d = count_q;
        if (redirect && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end

        redirect_count = rst ? 8'h00 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            target_q <= 16'h0000;
            count_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
        end
    end

endmodule
